dino_collision: RTL

Game-control stage directly downstream of the dinosaur motion block. It takes the dinosaur's registered position (`dino_h`, `dino_v`) and the current obstacle's position, and tests them for overlap once per game frame. It also runs the IDLE/RUN/HIT/OVER game state machine and keeps a 4-digit BCD score. Its `run_enable` output gates the motion and obstacle blocks, and its score and state outputs feed the VGA renderer.

---
 rtl/dino_pkg.sv | 33 +++
 rtl/dino_collision_if.sv | 38 +++
 rtl/bcd_counter4.sv | 43 ++++
 rtl/dino_collision.sv | 137 +++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// dino_pkg: constants and types shared by the dinosaur game blocks
// (motion, collision/game control, renderer).
//   game_state_t : IDLE/RUN/HIT/OVER encoding seen on game_state
//   DINO_SIZE    : dinosaur bounding-box edge in pixels
//   GROUND_Y     : y of the ground line
//   SCREEN_W/H   : visible screen size in pixels
//   bcd_digit_inc: one BCD digit +1 with carry out
package dino_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHit  = 2'd2,
    StOver = 2'd3
  } game_state_t;

  localparam int unsigned DINO_SIZE = 40;
  localparam int unsigned GROUND_Y  = 440;
  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;

  // Pixel coordinate width, wide enough for either screen dimension.
  localparam int unsigned COORD_W   = 10;

  // Returns {carry_out, next_digit}; 9 rolls to 0 with carry.
  function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d);
    if (d >= 4'd9) begin
      return 5'b1_0000;
    end
    return {1'b0, d + 4'd1};
  endfunction

endpackage

// File: rtl/dino_collision_if.sv
// dino_collision_if: game-control signal bundle between the collision /
// game-state block and its neighbours.
//   frame_tick   : one-cycle pulse per game frame
//   start_button : debounced start level, high = pressed
//   dino_h/v     : dinosaur left x / top y
//   obs_h/v      : obstacle left x / top y
//   obs_valid    : obstacle on screen
//   game_state   : IDLE/RUN/HIT/OVER
//   run_enable   : high only in RUN, gates motion and obstacle blocks
//   hit_pulse    : one-cycle pulse on collision
//   score_bcd    : four BCD digits, ones in [3:0]
// slave  = the collision block; master = whoever drives it (top level / bench).
interface dino_collision_if;
  import dino_pkg::*;

  logic               frame_tick;
  logic               start_button;
  logic [COORD_W-1:0] dino_h;
  logic [COORD_W-1:0] dino_v;
  logic [COORD_W-1:0] obs_h;
  logic [COORD_W-1:0] obs_v;
  logic               obs_valid;
  game_state_t        game_state;
  logic               run_enable;
  logic               hit_pulse;
  logic [15:0]        score_bcd;

  modport master (
    output frame_tick, start_button, dino_h, dino_v, obs_h, obs_v, obs_valid,
    input  game_state, run_enable, hit_pulse, score_bcd
  );

  modport slave (
    input  frame_tick, start_button, dino_h, dino_v, obs_h, obs_v, obs_valid,
    output game_state, run_enable, hit_pulse, score_bcd
  );

endinterface

// File: rtl/bcd_counter4.sv
// bcd_counter4: four-digit BCD up-counter that saturates at 9999.
//   clk : clock
//   rst : synchronous active-low reset, clears to 0000
//   clr : synchronous clear (wins over inc)
//   inc : add one, ignored once the count is 9999
//   q   : count, ones digit in q[3:0]
module bcd_counter4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] q
);
  import dino_pkg::*;

  logic [15:0] q_q, q_d;
  logic        carry;

  always_comb begin
    q_d   = q_q;
    carry = inc && (q_q != 16'h9999);
    // Ripple the +1 up the digits; a digit only changes while a carry reaches it.
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        {carry, q_d[4*i +: 4]} = bcd_digit_inc(q_q[4*i +: 4]);
      end
    end
    if (clr) begin
      q_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/dino_collision.sv
// dino_collision: per-frame dinosaur/obstacle overlap test, IDLE/RUN/HIT/OVER
// game FSM and BCD score keeping.
//   clk : system clock
//   rst : synchronous active-low reset
//   bus : dino_collision_if.slave (frame tick, start button, positions in;
//         game_state, run_enable, hit_pulse, score_bcd out)
// Parameters: DINO_SIZE, OBS_W, OBS_HT in pixels; SCORE_DIV frames per score
// step (1..63); HIT_FRAMES frames spent in HIT before OVER (1..63).
module dino_collision #(
  parameter int unsigned DINO_SIZE  = dino_pkg::DINO_SIZE,
  parameter int unsigned OBS_W      = 20,
  parameter int unsigned OBS_HT     = 40,
  parameter int unsigned SCORE_DIV  = 6,
  parameter int unsigned HIT_FRAMES = 30
) (
  input logic             clk,
  input logic             rst,
  dino_collision_if.slave bus
);
  import dino_pkg::*;

  localparam logic [5:0] DivLast = 6'(SCORE_DIV - 1);
  localparam logic [5:0] HitLast = 6'(HIT_FRAMES - 1);

  game_state_t state_q, state_d;
  logic [5:0]  div_q, div_d;
  logic [5:0]  hit_cnt_q, hit_cnt_d;
  logic        start_q;
  logic        run_en_q, run_en_d;
  logic        hit_pulse_q, hit_pulse_d;
  logic        score_clr, score_inc;
  logic [15:0] score;
  logic        start_rise;
  logic        overlap;

  // Zero-extended to 11 bits so right/bottom edges near 1023 never wrap.
  logic [10:0] dino_l, dino_r, dino_t, dino_b;
  logic [10:0] obs_l, obs_r, obs_t, obs_b;

  assign dino_l = {1'b0, bus.dino_h};
  assign dino_t = {1'b0, bus.dino_v};
  assign obs_l  = {1'b0, bus.obs_h};
  assign obs_t  = {1'b0, bus.obs_v};
  assign dino_r = dino_l + 11'(DINO_SIZE);
  assign dino_b = dino_t + 11'(DINO_SIZE);
  assign obs_r  = obs_l + 11'(OBS_W);
  assign obs_b  = obs_t + 11'(OBS_HT);

  // Strict compares: boxes sharing only an edge do not collide.
  assign overlap = bus.obs_valid
                 && (dino_l < obs_r) && (obs_l < dino_r)
                 && (dino_t < obs_b) && (obs_t < dino_b);

  assign start_rise = bus.start_button && !start_q;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    hit_cnt_d   = hit_cnt_q;
    hit_pulse_d = 1'b0;
    score_clr   = 1'b0;
    score_inc   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_rise) begin
          state_d   = StRun;
          div_d     = '0;
          hit_cnt_d = '0;
          score_clr = 1'b1;
        end
      end
      StRun: begin
        if (bus.frame_tick) begin
          if (overlap) begin
            // Collision beats a divider rollover on the same frame.
            state_d     = StHit;
            hit_pulse_d = 1'b1;
            hit_cnt_d   = '0;
          end else if (div_q == DivLast) begin
            div_d     = '0;
            score_inc = 1'b1;
          end else begin
            div_d = div_q + 6'd1;
          end
        end
      end
      StHit: begin
        if (bus.frame_tick) begin
          if (hit_cnt_q == HitLast) begin
            state_d = StOver;
          end else begin
            hit_cnt_d = hit_cnt_q + 6'd1;
          end
        end
      end
      StOver: begin
        if (start_rise) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    run_en_d = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      div_q       <= '0;
      hit_cnt_q   <= '0;
      start_q     <= 1'b0;
      run_en_q    <= 1'b0;
      hit_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      hit_cnt_q   <= hit_cnt_d;
      start_q     <= bus.start_button;
      run_en_q    <= run_en_d;
      hit_pulse_q <= hit_pulse_d;
    end
  end

  bcd_counter4 u_score (
    .clk (clk),
    .rst (rst),
    .clr (score_clr),
    .inc (score_inc),
    .q   (score)
  );

  assign bus.game_state = state_q;
  assign bus.run_enable = run_en_q;
  assign bus.hit_pulse  = hit_pulse_q;
  assign bus.score_bcd  = score;

endmodule
